// File: rtl/instr_enc_loader.sv
// RV32I field-to-word encoder that streams encoded instructions into instruction RAM.
// Optional macro INSTR_ENC_CHECK_EN enables immediate range/alignment checking (err_code 2).
module instr_enc_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_func3,
    input  logic [6:0]        in_func7,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W+1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
    typedef enum logic [1:0] {E_NONE, E_FMT, E_IMM, E_OVF} err_e;

    localparam logic [2:0] FMT_LOAD  = 3'd0;
    localparam logic [2:0] FMT_ALUI  = 3'd1;
    localparam logic [2:0] FMT_STORE = 3'd2;
    localparam logic [2:0] FMT_R     = 3'd3;
    localparam logic [2:0] FMT_B     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_ALUI  = 7'b0010011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_J     = 7'b1101111;

    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

    state_e            state, state_nx;
    err_e              err_q;
    logic [ADDR_W-1:0] ptr;
    logic              full;      // pointer has run past the last word
    logic              out_valid;
    logic              out_last;
    logic [31:0]       out_data;

    logic [31:0] enc;
    logic        illegal, imm_bad;
    logic        accept, complete, drop, load, restart, ovf_pending;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        enc = '0;
        case (in_fmt)
            FMT_LOAD:  enc = {in_imm[11:0], in_rs1, in_func3, in_rd, OP_LOAD};
            FMT_ALUI:  enc = {in_imm[11:0], in_rs1, in_func3, in_rd, OP_ALUI};
            FMT_STORE: enc = {in_imm[11:5], in_rs2, in_rs1, in_func3, in_imm[4:0], OP_STORE};
            FMT_R:     enc = {in_func7, in_rs2, in_rs1, in_func3, in_rd, OP_R};
            FMT_B:     enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_func3,
                              in_imm[4:1], in_imm[11], OP_B};
            FMT_J:     enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_J};
            default:   enc = '0;
        endcase
    end

`ifdef INSTR_ENC_CHECK_EN
    // An immediate fits when all bits above the field's sign bit match the sign bit.
    always_comb begin
        imm_bad = 1'b0;
        case (in_fmt)
            FMT_LOAD, FMT_ALUI, FMT_STORE:
                imm_bad = (|in_imm[31:11]) && !(&in_imm[31:11]);
            FMT_B:
                imm_bad = ((|in_imm[31:12]) && !(&in_imm[31:12])) || in_imm[0];
            FMT_J:
                imm_bad = ((|in_imm[31:20]) && !(&in_imm[31:20])) || in_imm[0];
            default:
                imm_bad = 1'b0;
        endcase
    end
`else
    logic unused_imm_bits;
    assign unused_imm_bits = ^in_imm[31:21];
    assign imm_bad = 1'b0;
`endif

    assign illegal     = (in_fmt > FMT_J);
    assign ovf_pending = out_valid && (ptr == PTR_MAX);
    assign accept      = in_valid && in_ready;
    assign complete    = out_valid && mem_ready;
    assign drop        = accept && (full || illegal || imm_bad);
    assign load        = accept && !drop;
    assign restart     = start && (state != S_RUN);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_RUN;
            end
            S_RUN: begin
                in_ready = (!out_valid || mem_ready) && !ovf_pending && !(out_valid && out_last);
                if (accept && full)
                    state_nx = S_DONE;
                else if (complete && out_last)
                    state_nx = S_DONE;
                else if (drop && in_last && !(out_valid && !mem_ready))
                    state_nx = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_nx = S_RUN;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            count     <= '0;
            full      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            err       <= 1'b0;
            err_q     <= E_NONE;
        end else if (restart) begin
            ptr       <= base_addr;
            count     <= '0;
            full      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            err       <= 1'b0;
            err_q     <= E_NONE;
        end else begin
            if (complete) begin
                ptr       <= ptr + 1'b1;
                count     <= count + 1'b1;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                if (ptr == PTR_MAX) full <= 1'b1;
            end
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= enc;
                out_last  <= in_last;
            end
            // A dropped final instruction hands the "last" role to the word still waiting.
            if (drop && in_last && out_valid && !mem_ready) out_last <= 1'b1;
            if (drop) begin
                err <= 1'b1;
                if (!err) begin
                    if (full)         err_q <= E_OVF;
                    else if (illegal) err_q <= E_FMT;
                    else              err_q <= E_IMM;
                end
            end
        end
    end

    assign mem_we    = out_valid;
    assign mem_addr  = {ptr, 2'b00};
    assign mem_wdata = out_data;
    assign err_code  = err_q;

endmodule

// File: tb/tb_instr_enc_loader.sv
// Scoreboard bench for instr_enc_loader: two instances (ADDR_W=8 and ADDR_W=2) share one stimulus bus.
module tb_instr_enc_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        sel;
    logic        start, in_valid, in_last, mem_ready;
    logic [7:0]  base_addr;
    logic [2:0]  in_fmt, in_func3;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [6:0]  in_func7;
    logic [31:0] in_imm;

    logic        ir0, we0, done0, err0;
    logic [9:0]  addr0;
    logic [31:0] wd0;
    logic [8:0]  cnt0;
    logic [1:0]  ec0;

    logic        ir1, we1, done1, err1;
    logic [3:0]  addr1;
    logic [31:0] wd1;
    logic [2:0]  cnt1;
    logic [1:0]  ec1;

    instr_enc_loader #(.ADDR_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start & !sel), .base_addr(base_addr),
        .in_valid(in_valid & !sel), .in_ready(ir0), .in_fmt(in_fmt), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_func3(in_func3), .in_func7(in_func7),
        .in_imm(in_imm), .in_last(in_last), .mem_we(we0), .mem_addr(addr0),
        .mem_wdata(wd0), .mem_ready(mem_ready), .count(cnt0), .done(done0),
        .err(err0), .err_code(ec0)
    );

    instr_enc_loader #(.ADDR_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start & sel), .base_addr(base_addr[1:0]),
        .in_valid(in_valid & sel), .in_ready(ir1), .in_fmt(in_fmt), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_func3(in_func3), .in_func7(in_func7),
        .in_imm(in_imm), .in_last(in_last), .mem_we(we1), .mem_addr(addr1),
        .mem_wdata(wd1), .mem_ready(mem_ready), .count(cnt1), .done(done1),
        .err(err1), .err_code(ec1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s @%0t", name, $time);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t q0[$];
    wr_t q1[$];
    int  wr_cyc[$];
    int  cyc = 0;
    int  stall_seen = 0;
    logic        stall_prev = 1'b0;
    logic [31:0] prev_addr = '0, prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on every completed write, checks hold behaviour while stalled.
    always @(negedge clk) begin
        if (rst_n) begin
            if (we0 && stall_prev) begin
                check("stall_addr_hold", {22'd0, addr0}, prev_addr);
                check("stall_data_hold", wd0, prev_data);
            end
            if (we0 && !mem_ready) begin
                check("stall_in_ready", ir0, 1'b0);
                stall_seen <= stall_seen + 1;
                stall_prev <= 1'b1;
                prev_addr  <= {22'd0, addr0};
                prev_data  <= wd0;
            end else begin
                stall_prev <= 1'b0;
            end
            if (we0 && mem_ready) begin
                wr_cyc.push_back(cyc);
                if (q0.size() == 0) fail_now("u0_unexpected_write");
                else begin
                    wr_t e;
                    e = q0.pop_front();
                    check("u0_addr", {22'd0, addr0}, e.addr);
                    check("u0_data", wd0, e.data);
                end
            end
            if (we1 && mem_ready) begin
                if (q1.size() == 0) fail_now("u1_unexpected_write");
                else begin
                    wr_t e;
                    e = q1.pop_front();
                    check("u1_addr", {28'd0, addr1}, e.addr);
                    check("u1_data", wd1, e.data);
                end
            end
        end
    end

    task automatic push0(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        q0.push_back(e);
    endtask

    task automatic push1(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        q1.push_back(e);
    endtask

    task automatic do_start(input logic [7:0] base);
        base_addr = base;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send(input logic [2:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input logic last);
        bit ok = 1'b0;
        in_fmt = fmt; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_func3 = f3; in_func7 = f7; in_imm = imm; in_last = last;
        in_valid = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if ((sel ? ir1 : ir0) === 1'b1) begin
                @(posedge clk);
                #1 ok = 1'b1;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) fail_now("send_timeout");
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if ((sel ? done1 : done0) === 1'b1) seen = 1'b1;
        end
        if (!seen) fail_now("done_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        sel = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; mem_ready = 1'b1;
        base_addr = '0; in_fmt = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_func3 = '0; in_func7 = '0; in_imm = '0;

        // Reset state
        #2;
        check("rst_in_ready", ir0, 1'b0);
        check("rst_mem_we", we0, 1'b0);
        check("rst_mem_addr", addr0, 10'd0);
        check("rst_mem_wdata", wd0, 32'd0);
        check("rst_count", cnt0, 9'd0);
        check("rst_done", done0, 1'b0);
        check("rst_err", {err0, ec0}, 3'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", ir0, 1'b0);

        // addi x1,x0,5 at base 0
        do_start(8'h00);
        push0(32'h000, 32'h00500093);
        send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1);
        wait_done();
        check("t1_count", cnt0, 9'd1);
        check("t1_err", err0, 1'b0);

        // Full-rate stream ending with jal
        wr_cyc.delete();
        do_start(8'h40);
        push0(32'h100, 32'h0080A103);
        push0(32'h104, 32'h0020A223);
        push0(32'h108, 32'h002081B3);
        push0(32'h10C, 32'h402081B3);
        push0(32'h110, 32'hFE208EE3);
        push0(32'h114, 32'h008000EF);
        send(3'd0, 5'd2, 5'd1, 5'd0, 3'd2, 7'd0,    32'd8,  1'b0);
        send(3'd2, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0,    32'd4,  1'b0);
        send(3'd3, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00,   32'd0,  1'b0);
        send(3'd3, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20,   32'd0,  1'b0);
        send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0,    -32'sd4, 1'b0);
        send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,    32'd8,  1'b1);
        wait_done();
        check("stream_count", cnt0, 9'd6);
        check("stream_done", done0, 1'b1);
        check("stream_writes", wr_cyc.size(), 6);
        if (wr_cyc.size() == 6) check("stream_rate", wr_cyc[5] - wr_cyc[0], 5);

        // Backpressure mid-stream
        stall_seen = 0;
        do_start(8'h80);
        push0(32'h200, 32'h00100293);
        push0(32'h204, 32'h00200313);
        push0(32'h208, 32'h00300393);
        fork
            begin
                send(3'd1, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0);
                send(3'd1, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b0);
                send(3'd1, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b1);
            end
            begin
                bit seen = 1'b0;
                for (int n = 0; n < 50 && !seen; n++) begin
                    @(negedge clk);
                    if (we0) seen = 1'b1;
                end
                @(posedge clk);
                #1 mem_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 mem_ready = 1'b1;
            end
        join
        wait_done();
        check("stall_count", cnt0, 9'd3);
        check("stall_cycles", stall_seen, 3);

        // Illegal format then a legal addi at the un-incremented address
        do_start(8'h10);
        push0(32'h040, 32'h00500093);
        send(3'd7, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
        send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1);
        wait_done();
        check("fmt_err", err0, 1'b1);
        check("fmt_err_code", ec0, 2'd1);
        check("fmt_count", cnt0, 9'd1);

        // Misaligned branch offset
        do_start(8'h20);
`ifdef INSTR_ENC_CHECK_EN
        send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 1'b1);
        wait_done();
        check("bimm_err", err0, 1'b1);
        check("bimm_err_code", ec0, 2'd2);
        check("bimm_count", cnt0, 9'd0);
`else
        push0(32'h080, 32'h00208163);
        send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 1'b1);
        wait_done();
        check("bimm_err", {err0, ec0}, 3'd0);
        check("bimm_count", cnt0, 9'd1);
`endif

        // Address overflow on the ADDR_W=2 instance
        sel = 1'b1;
        do_start(8'h03);
        push1(32'h00C, 32'h00500093);
        send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
        send(3'd1, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b0);
        wait_done();
        check("ovf_err", err1, 1'b1);
        check("ovf_err_code", ec1, 2'd3);
        check("ovf_count", cnt1, 3'd1);
        check("ovf_done", done1, 1'b1);

        // Reset while a write is held pending
        do_start(8'h00);
        mem_ready = 1'b0;
        send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
        @(negedge clk);
        check("pend_we", we1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_we", we1, 1'b0);
        check("arst_addr", addr1, 4'd0);
        check("arst_wdata", wd1, 32'd0);
        check("arst_count", cnt1, 3'd0);
        check("arst_flags", {done1, err1, ec1, ir1}, 5'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        mem_ready = 1'b1;
        sel = 1'b0;
        repeat (2) @(posedge clk);

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
